// File: rtl/dlsc_dma_write_burst_if.sv
// dlsc_dma_write_burst_if
//   Bundles the command, read-FIFO and AXI write-channel signals of the DMA
//   write burst engine.
//   master : engine side (drives cmd_ready, fifo_rd_pop, AW/W valids, B ready)
//   slave  : environment side (command source, FIFO, AXI slave)
interface dlsc_dma_write_burst_if #(
    parameter int DATA = 32,
    parameter int ADDR = 32,
    parameter int LEN  = 4,
    parameter int BUFA = 9
);
    localparam int STRB = DATA / 8;

    // command
    logic              cmd_ready;
    logic              cmd_valid;
    logic [ADDR-1:0]   cmd_addr;
    logic [LEN-1:0]    cmd_len;
    logic [STRB-1:0]   cmd_strb_first;
    logic [STRB-1:0]   cmd_strb_last;
    // read FIFO
    logic              fifo_rd_pop;
    logic [DATA-1:0]   fifo_rd_data;
    logic [BUFA:0]     fifo_rd_count;
    logic              fifo_rd_empty;
    // AXI AW
    logic              axi_aw_ready;
    logic              axi_aw_valid;
    logic [ADDR-1:0]   axi_aw_addr;
    logic [LEN-1:0]    axi_aw_len;
    // AXI W
    logic              axi_w_ready;
    logic              axi_w_valid;
    logic              axi_w_last;
    logic [STRB-1:0]   axi_w_strb;
    logic [DATA-1:0]   axi_w_data;
    // AXI B
    logic              axi_b_ready;
    logic              axi_b_valid;
    logic [1:0]        axi_b_resp;

    modport master (
        output cmd_ready,
        input  cmd_valid, cmd_addr, cmd_len, cmd_strb_first, cmd_strb_last,
        output fifo_rd_pop,
        input  fifo_rd_data, fifo_rd_count, fifo_rd_empty,
        input  axi_aw_ready,
        output axi_aw_valid, axi_aw_addr, axi_aw_len,
        input  axi_w_ready,
        output axi_w_valid, axi_w_last, axi_w_strb, axi_w_data,
        output axi_b_ready,
        input  axi_b_valid, axi_b_resp
    );

    modport slave (
        input  cmd_ready,
        output cmd_valid, cmd_addr, cmd_len, cmd_strb_first, cmd_strb_last,
        input  fifo_rd_pop,
        output fifo_rd_data, fifo_rd_count, fifo_rd_empty,
        output axi_aw_ready,
        input  axi_aw_valid, axi_aw_addr, axi_aw_len,
        output axi_w_ready,
        input  axi_w_valid, axi_w_last, axi_w_strb, axi_w_data,
        input  axi_b_ready,
        output axi_b_valid, axi_b_resp
    );
endinterface

// File: rtl/dlsc_dma_write_burst.sv
// dlsc_dma_write_burst
//   DMA write engine: turns per-burst commands into AXI AW/W bursts fed from a
//   local read FIFO. FIFO words are reserved when a command is accepted, so the
//   W engine pops without ever checking for data. B responses retire bursts and
//   accumulate sticky error flags.
// Ports
//   clk, rst    clock, async active-high reset
//   halt        stop accepting commands (accepted bursts still complete)
//   busy        any burst accepted and not yet B-responded
//   error       sticky [0] SLVERR, [1] DECERR
//   burst_done  1-cycle pulse per B handshake
//   bus         command / FIFO / AXI write signals (master modport)
module dlsc_dma_write_burst #(
    parameter int DATA = 32,
    parameter int ADDR = 32,
    parameter int LEN  = 4,
    parameter int BUFA = 9,
    parameter int MOT  = 16,
    parameter int WQA  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   halt,
    output logic                   busy,
    output logic [1:0]             error,
    output logic                   burst_done,
    dlsc_dma_write_burst_if.master bus
);
    localparam int STRB = DATA / 8;
    localparam int WQD  = 1 << WQA;
    localparam int RW   = BUFA + 1;   // reserved counter width (<= FIFO depth)
    localparam int CW   = BUFA + 2;   // space compare width, never wraps
    localparam int OW   = 8;          // outstanding counter (MOT <= 255)

    typedef struct packed {
        logic [LEN-1:0]  len;
        logic [STRB-1:0] sf;
        logic [STRB-1:0] sl;
    } wq_ent_t;

    typedef enum logic {W_IDLE, W_ACTIVE} w_state_t;

    // AW channel registers
    logic            aw_valid_q;
    logic [ADDR-1:0] aw_addr_q;
    logic [LEN-1:0]  aw_len_q;

    // W-side queue of accepted bursts (extra pointer bit distinguishes full/empty)
    wq_ent_t         wq_mem [WQD];
    logic [WQA:0]    wq_wr_q, wq_rd_q;
    logic            wq_empty, wq_full;

    // bookkeeping
    logic [RW-1:0]   reserved_q, reserved_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [1:0]      error_q;
    logic            burst_done_q;

    // W engine
    w_state_t        w_state_q, w_state_d;
    wq_ent_t         cur_q;
    logic [LEN-1:0]  beat_q;
    logic            w_valid_q, w_last_q;
    logic [STRB-1:0] w_strb_q;
    logic [DATA-1:0] w_data_q;
    logic            slot_free, w_deq, w_pop, final_beat;
    logic [STRB-1:0] strb_sel;

    // accept path
    logic            b_hs, accept, cmd_ready_c, space_ok, mot_ok;
    logic [CW-1:0]   need;

    // Emptiness is implied by the reservation scheme; not needed here.
    logic            unused_empty;
    assign unused_empty = bus.fifo_rd_empty;

    assign wq_empty = (wq_wr_q == wq_rd_q);
    assign wq_full  = (wq_wr_q[WQA] != wq_rd_q[WQA]) &&
                      (wq_wr_q[WQA-1:0] == wq_rd_q[WQA-1:0]);

    assign b_hs = bus.axi_b_valid && bus.axi_b_ready;

    // A B handshake frees an outstanding slot in the same cycle, so a command
    // stalled on the limit can be taken on that very edge.
    assign mot_ok = (outstanding_q < OW'(MOT)) || b_hs;

    assign need     = CW'(reserved_q) + CW'(bus.cmd_len) + CW'(1);
    assign space_ok = (CW'(bus.fifo_rd_count) >= need);

    assign cmd_ready_c = !rst && !halt && (!aw_valid_q || bus.axi_aw_ready) &&
                         !wq_full && mot_ok && space_ok;
    assign accept      = cmd_ready_c && bus.cmd_valid;

    // ------------------------------------------------------------------
    // AW channel
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
        end else if (accept) begin
            aw_valid_q <= 1'b1;
            aw_addr_q  <= bus.cmd_addr;
            aw_len_q   <= bus.cmd_len;
        end else if (bus.axi_aw_ready) begin
            aw_valid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // W queue
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            wq_mem[wq_wr_q[WQA-1:0]] <= '{len: bus.cmd_len,
                                          sf:  bus.cmd_strb_first,
                                          sl:  bus.cmd_strb_last};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wq_wr_q <= '0;
            wq_rd_q <= '0;
        end else begin
            if (accept) wq_wr_q <= wq_wr_q + 1'b1;
            if (w_deq)  wq_rd_q <= wq_rd_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Reservation / outstanding / B
    // ------------------------------------------------------------------
    always_comb begin
        reserved_d = reserved_q;
        if (accept) reserved_d = reserved_d + RW'(bus.cmd_len) + RW'(1);
        if (w_pop)  reserved_d = reserved_d - RW'(1);
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !b_hs)      outstanding_d = outstanding_q + OW'(1);
        else if (!accept && b_hs) outstanding_d = outstanding_q - OW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reserved_q    <= '0;
            outstanding_q <= '0;
            error_q       <= '0;
            burst_done_q  <= 1'b0;
        end else begin
            reserved_q    <= reserved_d;
            outstanding_q <= outstanding_d;
            burst_done_q  <= b_hs;
            if (b_hs && bus.axi_b_resp == 2'b10) error_q[0] <= 1'b1;
            if (b_hs && bus.axi_b_resp == 2'b11) error_q[1] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // W engine
    // ------------------------------------------------------------------
    assign slot_free  = !w_valid_q || bus.axi_w_ready;
    assign final_beat = (beat_q == cur_q.len);

    always_comb begin
        strb_sel = '1;
        if (beat_q == '0 && final_beat) strb_sel = cur_q.sf & cur_q.sl;
        else if (beat_q == '0)          strb_sel = cur_q.sf;
        else if (final_beat)            strb_sel = cur_q.sl;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_state_q <= W_IDLE;
        else     w_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = w_state_q;
        w_deq     = 1'b0;
        w_pop     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (!wq_empty && slot_free) begin
                    w_deq     = 1'b1;
                    w_state_d = W_ACTIVE;
                end
            end
            W_ACTIVE: begin
                if (slot_free) begin
                    w_pop = 1'b1;
                    // Chain straight into the next queued burst to avoid a bubble.
                    if (final_beat) begin
                        if (!wq_empty) w_deq     = 1'b1;
                        else           w_state_d = W_IDLE;
                    end
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q     <= '0;
            beat_q    <= '0;
            w_valid_q <= 1'b0;
            w_last_q  <= 1'b0;
            w_strb_q  <= '0;
            w_data_q  <= '0;
        end else begin
            if (w_deq) begin
                cur_q  <= wq_mem[wq_rd_q[WQA-1:0]];
                beat_q <= '0;
            end else if (w_pop) begin
                beat_q <= beat_q + 1'b1;
            end
            if (w_pop) begin
                w_valid_q <= 1'b1;
                w_data_q  <= bus.fifo_rd_data;
                w_strb_q  <= strb_sel;
                w_last_q  <= final_beat;
            end else if (bus.axi_w_ready) begin
                w_valid_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.cmd_ready    = cmd_ready_c;
    assign bus.fifo_rd_pop  = w_pop;
    assign bus.axi_aw_valid = aw_valid_q;
    assign bus.axi_aw_addr  = aw_addr_q;
    assign bus.axi_aw_len   = aw_len_q;
    assign bus.axi_w_valid  = w_valid_q;
    assign bus.axi_w_last   = w_last_q;
    assign bus.axi_w_strb   = w_strb_q;
    assign bus.axi_w_data   = w_data_q;
    assign bus.axi_b_ready  = (outstanding_q != '0);
    assign busy             = (outstanding_q != '0);
    assign error            = error_q;
    assign burst_done       = burst_done_q;

endmodule

// File: tb/tb_dlsc_dma_write_burst.sv
// tb_dlsc_dma_write_burst
//   Randomized scoreboard bench: accepted commands are expanded into expected
//   AW and W beats (queues); a negedge monitor pops and compares on every
//   handshake and tracks busy/error/burst_done against counters.
module tb_dlsc_dma_write_burst;
    localparam int DATA = 32, ADDR = 32, LEN = 4, BUFA = 9, MOT = 2, WQA = 2;
    localparam int STRB = DATA / 8;

    logic clk = 1'b0, rst = 1'b1, halt = 1'b0;
    logic busy, burst_done;
    logic [1:0] error;

    dlsc_dma_write_burst_if #(.DATA(DATA), .ADDR(ADDR), .LEN(LEN), .BUFA(BUFA)) bus ();

    dlsc_dma_write_burst #(.DATA(DATA), .ADDR(ADDR), .LEN(LEN), .BUFA(BUFA),
                           .MOT(MOT), .WQA(WQA)) dut (
        .clk(clk), .rst(rst), .halt(halt), .busy(busy), .error(error),
        .burst_done(burst_done), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed { logic [STRB-1:0] strb; logic last; } wexp_t;
    typedef struct packed { logic [ADDR-1:0] addr; logic [LEN-1:0] len; } awexp_t;

    int errors = 0, checks = 0;
    logic [DATA-1:0] fq[$];        // FIFO contents presented to the DUT
    logic [DATA-1:0] wstream[$];   // every word ever written, in order
    wexp_t  exp_w[$];
    awexp_t exp_aw[$];
    logic [1:0] resp_q[$];
    int acc_cnt = 0, aw_cnt = 0, wl_cnt = 0, bh_cnt = 0, b_issued = 0, done_cnt = 0;
    logic [1:0] err_model = 2'b00;
    bit prev_b = 0, chk_en = 0, b_en = 1, pop_seen = 0, b_hs_seen = 0;
    int rdy_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        wexp_t e;
        awexp_t a;
        logic [DATA-1:0] d;
        pop_seen  = chk_en && bus.fifo_rd_pop;
        b_hs_seen = chk_en && bus.axi_b_valid && bus.axi_b_ready;
        if (chk_en) begin
            check("busy", busy, acc_cnt != bh_cnt);
            check("b_ready", bus.axi_b_ready, acc_cnt != bh_cnt);
            check("error", error, err_model);
            check("burst_done", burst_done, prev_b);
            if (burst_done) done_cnt++;
            if (halt) check("halt_ready", bus.cmd_ready, 0);
            if (bus.fifo_rd_pop && fq.size() == 0) fail_now("pop_empty");
            prev_b = b_hs_seen;
            if (bus.cmd_valid && bus.cmd_ready) begin
                acc_cnt++;
                exp_aw.push_back('{addr: bus.cmd_addr, len: bus.cmd_len});
                for (int b = 0; b <= int'(bus.cmd_len); b++) begin
                    if (bus.cmd_len == 0)          e.strb = bus.cmd_strb_first & bus.cmd_strb_last;
                    else if (b == 0)               e.strb = bus.cmd_strb_first;
                    else if (b == int'(bus.cmd_len)) e.strb = bus.cmd_strb_last;
                    else                           e.strb = '1;
                    e.last = (b == int'(bus.cmd_len));
                    exp_w.push_back(e);
                end
            end
            if (bus.axi_aw_valid && bus.axi_aw_ready) begin
                aw_cnt++;
                if (exp_aw.size() == 0) fail_now("aw_unexpected");
                else begin
                    a = exp_aw.pop_front();
                    check("aw_addr", bus.axi_aw_addr, a.addr);
                    check("aw_len", bus.axi_aw_len, a.len);
                end
            end
            if (bus.axi_w_valid && bus.axi_w_ready) begin
                if (exp_w.size() == 0 || wstream.size() == 0) fail_now("w_unexpected");
                else begin
                    e = exp_w.pop_front();
                    d = wstream.pop_front();
                    check("w_data", bus.axi_w_data, d);
                    check("w_strb", bus.axi_w_strb, e.strb);
                    check("w_last", bus.axi_w_last, e.last);
                    if (e.last) wl_cnt++;
                end
            end
            if (b_hs_seen) begin
                bh_cnt++;
                if (bus.axi_b_resp == 2'b10) err_model[0] = 1'b1;
                if (bus.axi_b_resp == 2'b11) err_model[1] = 1'b1;
            end
        end
    end

    // ---------------- FIFO model ----------------
    always @(posedge clk) begin
        if (pop_seen) void'(fq.pop_front());
        #2;
        bus.fifo_rd_count = (BUFA+1)'(fq.size());
        bus.fifo_rd_empty = (fq.size() == 0);
        bus.fifo_rd_data  = (fq.size() != 0) ? fq[0] : '0;
    end

    // ---------------- AW/W ready ----------------
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       begin bus.axi_aw_ready = 1'($urandom_range(0, 1)); bus.axi_w_ready = 1'($urandom_range(0, 1)); end
            2:       begin bus.axi_aw_ready = 1'b1; bus.axi_w_ready = 1'b0; end
            default: begin bus.axi_aw_ready = 1'b1; bus.axi_w_ready = 1'b1; end
        endcase
    end

    // ---------------- B responder ----------------
    always @(posedge clk) begin
        #1;
        if (rst) begin
            bus.axi_b_valid = 1'b0;
            bus.axi_b_resp  = 2'b00;
        end else begin
            if (b_hs_seen) bus.axi_b_valid = 1'b0;
            if (!bus.axi_b_valid && b_en && wl_cnt > b_issued && aw_cnt > b_issued &&
                $urandom_range(0, 2) != 0) begin
                bus.axi_b_valid = 1'b1;
                bus.axi_b_resp  = (resp_q.size() != 0) ? resp_q.pop_front()
                                                       : ($urandom_range(0, 1) != 0 ? 2'b01 : 2'b00);
                b_issued++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic fifo_push(input int n);
        logic [DATA-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = DATA'($urandom);
            fq.push_back(w);
            wstream.push_back(w);
        end
    endtask

    task automatic wait_accept(input string name, input int bound);
        int n = 0;
        forever begin
            @(negedge clk);
            if (bus.cmd_ready) break;
            n++;
            if (n > bound) begin fail_now(name); break; end
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic set_cmd(input logic [ADDR-1:0] a, input int l,
                           input logic [STRB-1:0] sf, input logic [STRB-1:0] sl, input bit v);
        bus.cmd_addr       = a;
        bus.cmd_len        = LEN'(l);
        bus.cmd_strb_first = sf;
        bus.cmd_strb_last  = sl;
        bus.cmd_valid      = v;
    endtask

    task automatic send_cmd(input logic [ADDR-1:0] a, input int l,
                            input logic [STRB-1:0] sf, input logic [STRB-1:0] sl);
        @(posedge clk); #1;
        set_cmd(a, l, sf, sl, 1'b1);
        wait_accept("cmd_accept_timeout", 2000);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (exp_w.size() == 0 && exp_aw.size() == 0 && acc_cnt == bh_cnt) break;
            n++;
            if (n > 3000) begin fail_now(name); break; end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int l, n;
        bit seen;
        set_cmd('0, 0, '0, '0, 1'b0);
        // reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_pop", bus.fifo_rd_pop, 0);
        check("rst_aw_valid", bus.axi_aw_valid, 0);
        check("rst_w_valid", bus.axi_w_valid, 0);
        check("rst_w_last", bus.axi_w_last, 0);
        check("rst_b_ready", bus.axi_b_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_burst_done", burst_done, 0);
        check("rst_error", error, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // 1: single 4-beat burst
        fifo_push(4);
        send_cmd(32'h100, 3, 4'b1110, 4'b0111);
        wait_idle("t1_idle");
        check("t1_busy", busy, 0);
        check("t1_done_pulses", done_cnt, 1);

        // 2: single beat uses first & last strobe
        fifo_push(1);
        send_cmd(32'h204, 0, 4'b1100, 4'b0110);
        wait_idle("t2_idle");

        // 3: not enough FIFO data -> stall
        fifo_push(3);
        @(posedge clk); #1;
        set_cmd(32'h300, 3, 4'b1000, 4'b0001, 1'b1);
        repeat (6) begin
            @(negedge clk);
            check("t3_no_ready", bus.cmd_ready, 0);
            check("t3_no_w", bus.axi_w_valid, 0);
        end
        @(posedge clk); #1;
        fifo_push(1);
        wait_accept("t3_accept", 10);
        fifo_push(4);
        send_cmd(32'h340, 3, 4'b1111, 4'b0011);
        wait_idle("t3_idle");
        fifo_push(1);
        set_cmd(32'h380, 0, 4'b1111, 4'b1111, 1'b0);
        @(negedge clk);
        check("t3_resv_zero_len0", bus.cmd_ready, 1);
        @(posedge clk); #1;
        bus.cmd_len = LEN'(1);
        @(negedge clk);
        check("t3_resv_zero_len1", bus.cmd_ready, 0);
        send_cmd(32'h380, 0, 4'b1111, 4'b1111);
        wait_idle("t3b_idle");

        // 4: outstanding limit, release on B in the same cycle
        b_en = 1'b0;
        fifo_push(3);
        send_cmd(32'h400, 0, 4'b0001, 4'b0001);
        send_cmd(32'h404, 0, 4'b0010, 4'b0010);
        @(posedge clk); #1;
        set_cmd(32'h408, 0, 4'b0100, 4'b0100, 1'b1);
        repeat (8) begin
            @(negedge clk);
            check("t4_stall", bus.cmd_ready, 0);
        end
        @(posedge clk); #1;
        b_en = 1'b1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.axi_b_valid && bus.axi_b_ready) begin
                check("t4_same_cycle", bus.cmd_ready, 1);
                seen = 1;
            end else begin
                check("t4_stall_b", bus.cmd_ready, 0);
            end
        end
        if (!seen) fail_now("t4_no_b");
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        wait_idle("t4_idle");

        // 5: sticky errors, then random traffic with backpressure
        resp_q.push_back(2'b10);
        resp_q.push_back(2'b11);
        fifo_push(1);
        send_cmd(32'h500, 0, 4'b1111, 4'b1111);
        wait_idle("t5a_idle");
        check("t5_err_slv", error, 2'b01);
        fifo_push(1);
        send_cmd(32'h504, 0, 4'b1111, 4'b1111);
        wait_idle("t5b_idle");
        check("t5_err_dec", error, 2'b11);
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            l = $urandom_range(0, 15);
            fifo_push(l + 1);
            send_cmd(ADDR'($urandom), l, STRB'($urandom_range(1, 15)), STRB'($urandom_range(1, 15)));
        end
        wait_idle("t5_rand_idle");
        rdy_mode = 0;
        check("t5_err_sticky", error, 2'b11);

        // 6: halt mid-burst, then reset mid-burst
        fifo_push(16);
        send_cmd(32'h600, 15, 4'b1110, 4'b0111);
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.axi_w_valid && bus.axi_w_ready) break;
            n++;
            if (n > 50) begin fail_now("t6_first_w"); break; end
        end
        @(posedge clk); #1;
        halt = 1'b1;
        fifo_push(4);
        set_cmd(32'h680, 0, 4'b1111, 4'b1111, 1'b1);
        repeat (4) begin
            @(negedge clk);
            check("t6_halt_no_ready", bus.cmd_ready, 0);
        end
        wait_idle("t6_halt_idle");
        halt = 1'b0;
        wait_accept("t6_after_halt", 20);
        wait_idle("t6_idle");
        fifo_push(5);
        rdy_mode = 2;
        send_cmd(32'h700, 7, 4'b1111, 4'b1111);
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.axi_w_valid) break;
            n++;
            if (n > 50) begin fail_now("t6_w_valid"); break; end
        end
        chk_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("t6_rst_aw_valid", bus.axi_aw_valid, 0);
        check("t6_rst_w_valid", bus.axi_w_valid, 0);
        check("t6_rst_w_last", bus.axi_w_last, 0);
        check("t6_rst_pop", bus.fifo_rd_pop, 0);
        check("t6_rst_cmd_ready", bus.cmd_ready, 0);
        check("t6_rst_b_ready", bus.axi_b_ready, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_error", error, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
